// File: rtl/msk_skinny_pkg.sv
// Shared constants and types for the masked SKINNY-128 tweakey schedule.
// Holds the cell permutation, cell geometry, round defaults and FSM state type.
package msk_skinny_pkg;

   localparam int CELL_W  = 8;
   localparam int N_CELLS = 16;

   // New cell i takes old cell PT[i]; cell 0 is the most significant byte.
   localparam logic [3:0] PT [N_CELLS] = '{
      4'd9, 4'd15, 4'd8, 4'd13, 4'd10, 4'd14, 4'd12, 4'd11,
      4'd0, 4'd1,  4'd2, 4'd3,  4'd4,  4'd5,  4'd6,  4'd7
   };

   localparam int ROUNDS_Z1 = 40;
   localparam int ROUNDS_Z2 = 48;
   localparam int ROUNDS_Z3 = 56;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      LFSR_NONE = 2'd0,
      LFSR_TK2  = 2'd1,
      LFSR_TK3  = 2'd2
   } lfsr_mode_t;

   function automatic lfsr_mode_t word_mode(input int w);
      lfsr_mode_t m;
      case (w)
         0:       m = LFSR_NONE;
         1:       m = LFSR_TK2;
         2:       m = LFSR_TK3;
         default: m = LFSR_NONE;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/msk_tk_word_update.sv
// One round of the tweakey update on a single shared word: cell permutation
// followed by the row LFSR on cells 0..7. Pure wiring and per-share XORs.
module msk_tk_word_update
   import msk_skinny_pkg::*;
#(
   parameter int         D    = 2,
   parameter lfsr_mode_t MODE = LFSR_NONE
) (
   input  logic [128*D-1:0] word_in,
   output logic [128*D-1:0] word_out
);

   for (genvar s = 0; s < D; s++) begin : g_share
      for (genvar c = 0; c < N_CELLS; c++) begin : g_cell
         localparam int SRC = int'(PT[c]);
         logic [CELL_W-1:0] perm_s;
         logic [CELL_W-1:0] new_s;

         // Unshared bit j of share s lives at j*D+s.
         for (genvar b = 0; b < CELL_W; b++) begin : g_bit
            assign perm_s[b] = word_in[((N_CELLS-1-SRC)*CELL_W + b)*D + s];
            assign word_out[((N_CELLS-1-c)*CELL_W + b)*D + s] = new_s[b];
         end

         if (c < 8 && MODE == LFSR_TK2) begin : g_tk2
            assign new_s = {perm_s[6:0], perm_s[7] ^ perm_s[5]};
         end else if (c < 8 && MODE == LFSR_TK3) begin : g_tk3
            assign new_s = {perm_s[0] ^ perm_s[6], perm_s[7:1]};
         end else begin : g_pass
            assign new_s = perm_s;
         end
      end
   end

endmodule

// File: rtl/msk_tweakey_sched.sv
// Masked SKINNY-128 tweakey schedule: holds Z shared tweakey words, advances
// them one round per step and exposes the shared 64-bit round key.
module msk_tweakey_sched
   import msk_skinny_pkg::*;
#(
   parameter int D      = 2,
   parameter int Z      = 1,
   parameter int ROUNDS = ROUNDS_Z1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [128*Z*D-1:0] tk_in,
   input  logic               step,
   output logic [64*D-1:0]    rk_out,
   output logic               rk_valid,
   output logic [5:0]         round_idx,
   output logic               busy,
   output logic               done
);

   localparam int         WORD_W     = 128 * D;
   localparam int         RK_W       = 64 * D;
   localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

   state_t              state_r;
   logic [WORD_W*Z-1:0] tk_r;
   logic [WORD_W*Z-1:0] tk_next_s;
   logic [5:0]          round_r;
   logic                done_r;
   logic [RK_W-1:0]     rk_s;

   for (genvar w = 0; w < Z; w++) begin : g_word
      msk_tk_word_update #(
         .D    (D),
         .MODE (word_mode(w))
      ) u_update (
         .word_in  (tk_r[WORD_W*w +: WORD_W]),
         .word_out (tk_next_s[WORD_W*w +: WORD_W])
      );
   end

   // Round key: upper half (cells 0..7) of every word, XORed share by share.
   always_comb begin
      rk_s = '0;
      for (int w = 0; w < Z; w++) begin
         rk_s = rk_s ^ tk_r[WORD_W*w + RK_W +: RK_W];
      end
   end

   // Run control, round counter and tweakey state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         tk_r    <= '0;
         round_r <= 6'd0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  tk_r    <= tk_in;
                  round_r <= 6'd0;
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (start) begin
                  tk_r    <= tk_in;
                  round_r <= 6'd0;
               end else if (step) begin
                  // The last key is consumed without advancing the state.
                  if (round_r == LAST_ROUND) begin
                     state_r <= ST_IDLE;
                     done_r  <= 1'b1;
                  end else begin
                     tk_r    <= tk_next_s;
                     round_r <= round_r + 6'd1;
                  end
               end else begin
                  state_r <= ST_RUN;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign rk_out    = rk_s;
   assign rk_valid  = (state_r == ST_RUN);
   assign busy      = (state_r == ST_RUN);
   assign round_idx = round_r;
   assign done      = done_r;

endmodule
